// File: rtl/vga_rx_monitor.sv
// Receive-side VGA monitor: recovers pixel coordinates from sync edges,
// verifies raster timing and reports per-frame pixel statistics.
module vga_rx_monitor #(
  parameter int unsigned H_ACTIVE    = 640,
  parameter int unsigned H_FP        = 24,
  parameter int unsigned H_SYNC      = 40,
  parameter int unsigned H_BP        = 128,
  parameter int unsigned V_ACTIVE    = 480,
  parameter int unsigned V_FP        = 9,
  parameter int unsigned V_SYNC      = 3,
  parameter int unsigned V_BP        = 28,
  parameter bit          SYNC_ACTIVE = 1'b0
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        hsync,
  input  logic        vsync,
  input  logic [5:0]  rrggbb,
  output logic        locked,
  output logic        pix_valid,
  output logic [9:0]  pix_x,
  output logic [9:0]  pix_y,
  output logic [5:0]  pix_rgb,
  output logic        frame_done,
  output logic [15:0] frame_sum,
  output logic [18:0] lit_count,
  output logic [7:0]  err_count
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned XW      = 10;
  localparam int unsigned CW      = $clog2(2 * H_TOTAL + 1);
  localparam int unsigned FW      = $clog2(2 * V_TOTAL + 1);
  localparam int unsigned FW1     = FW + 1;
  localparam logic [CW-1:0] TMO   = CW'(2 * H_TOTAL - 1);

  typedef enum logic [1:0] {ST_SEARCH, ST_ACQUIRE, ST_LOCKED} state_t;

  state_t        state;
  logic          hs1, vs1, hs1_d, vs1_d;
  logic [5:0]    rgb1;
  logic [CW-1:0] h_cnt, hw_cnt;
  logic [FW-1:0] f_cnt;
  logic          hs_seen, frame_bad;
  logic [15:0]   acc_sum;
  logic [18:0]   acc_lit;

  logic          hs_act, hs_edge, hs_fall, vs_edge, x_wrap;
  logic [XW-1:0] x_n, y_n;
  logic [FW1-1:0] f_lines;
  logic          timeout, line_bad, width_bad, lines_bad;
  logic          drop, go_lock, lock_n, stat_cap, pix_lit;
  logic [5:0]    pix_add;

  // Edge detection, coordinate recovery and timing checks on the S1 stage
  always_comb begin
    hs_act    = (hs1 == SYNC_ACTIVE);
    hs_edge   = hs_act && (hs1_d != SYNC_ACTIVE);
    hs_fall   = !hs_act && (hs1_d == SYNC_ACTIVE);
    vs_edge   = (vs1 == SYNC_ACTIVE) && (vs1_d != SYNC_ACTIVE);
    x_wrap    = (pix_x == XW'(H_TOTAL - 1));
    x_n       = pix_x + XW'(1);
    if (hs_edge)     x_n = XW'(H_ACTIVE + H_FP);
    else if (x_wrap) x_n = '0;
    y_n = pix_y;
    if (vs_edge)
      y_n = XW'(V_ACTIVE + V_FP);
    else if (x_wrap && !hs_edge)
      y_n = (pix_y == XW'(V_TOTAL - 1)) ? '0 : pix_y + XW'(1);
    f_lines   = {1'b0, f_cnt} + FW1'(hs_edge);
    timeout   = !hs_edge && (h_cnt == TMO);
    line_bad  = hs_edge && hs_seen && (h_cnt != CW'(H_TOTAL - 1));
    width_bad = hs_fall && hs_seen && (hw_cnt != CW'(H_SYNC));
    lines_bad = vs_edge && (f_lines != FW1'(V_TOTAL));
    drop      = (state == ST_LOCKED) && (line_bad || width_bad || lines_bad || timeout);
    go_lock   = (state == ST_ACQUIRE) && vs_edge && !timeout && !frame_bad &&
                !line_bad && !width_bad && !lines_bad;
    lock_n    = ((state == ST_LOCKED) && !drop) || go_lock;
    stat_cap  = (state == ST_LOCKED) && !drop && vs_edge;
    pix_add   = pix_valid ? pix_rgb : 6'd0;
    pix_lit   = pix_valid && (pix_rgb != 6'd0);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ST_SEARCH;
      hs1        <= !SYNC_ACTIVE;
      vs1        <= !SYNC_ACTIVE;
      hs1_d      <= !SYNC_ACTIVE;
      vs1_d      <= !SYNC_ACTIVE;
      rgb1       <= '0;
      h_cnt      <= '0;
      hw_cnt     <= '0;
      f_cnt      <= '0;
      hs_seen    <= 1'b0;
      frame_bad  <= 1'b0;
      acc_sum    <= '0;
      acc_lit    <= '0;
      locked     <= 1'b0;
      pix_valid  <= 1'b0;
      pix_x      <= '0;
      pix_y      <= '0;
      pix_rgb    <= '0;
      frame_done <= 1'b0;
      frame_sum  <= '0;
      lit_count  <= '0;
      err_count  <= '0;
    end else begin
      hs1   <= hsync;
      vs1   <= vsync;
      rgb1  <= rrggbb;
      hs1_d <= hs1;
      vs1_d <= vs1;

      // Measurement counters saturate so a dead link cannot alias to a good one
      if (hs_edge)             h_cnt <= '0;
      else if (h_cnt != TMO)   h_cnt <= h_cnt + CW'(1);
      if (hs_edge)             hw_cnt <= CW'(1);
      else if (hs_act && hw_cnt != '1) hw_cnt <= hw_cnt + CW'(1);
      if (vs_edge)             f_cnt <= '0;
      else if (hs_edge && f_cnt != '1) f_cnt <= f_cnt + FW'(1);
      if (timeout)             hs_seen <= 1'b0;
      else if (hs_edge)        hs_seen <= 1'b1;

      pix_x     <= x_n;
      pix_y     <= y_n;
      pix_rgb   <= rgb1;
      locked    <= lock_n;
      pix_valid <= lock_n && (x_n < XW'(H_ACTIVE)) && (y_n < XW'(V_ACTIVE));

      case (state)
        ST_SEARCH: begin
          frame_bad <= 1'b0;
          if (vs_edge && !timeout) state <= ST_ACQUIRE;
        end
        ST_ACQUIRE: begin
          if (timeout) begin
            state <= ST_SEARCH;
          end else if (vs_edge) begin
            frame_bad <= 1'b0;
            if (go_lock) state <= ST_LOCKED;
          end else if (line_bad || width_bad) begin
            frame_bad <= 1'b1;
          end
        end
        ST_LOCKED: begin
          if (drop) state <= ST_SEARCH;
        end
        default: state <= ST_SEARCH;
      endcase

      if (drop && err_count != 8'hFF) err_count <= err_count + 8'd1;

      // Statistics only accumulate while locked; any other state keeps them zeroed
      frame_done <= 1'b0;
      if (stat_cap) begin
        frame_sum  <= acc_sum + 16'(pix_add);
        lit_count  <= acc_lit + 19'(pix_lit);
        frame_done <= 1'b1;
        acc_sum    <= '0;
        acc_lit    <= '0;
      end else if ((state == ST_LOCKED) && !drop) begin
        acc_sum <= acc_sum + 16'(pix_add);
        acc_lit <= acc_lit + 19'(pix_lit);
      end else begin
        acc_sum <= '0;
        acc_lit <= '0;
      end
    end
  end

endmodule

// File: tb/tb_vga_rx_monitor.sv
// Directed bench for vga_rx_monitor on a reduced 12x8 raster (6x4 visible).
module tb_vga_rx_monitor;

  localparam int HA = 6, HFP = 1, HSW = 2, HBP = 3;
  localparam int VA = 4, VFP = 1, VSW = 1, VBP = 2;
  localparam int HT = HA + HFP + HSW + HBP;
  localparam int VT = VA + VFP + VSW + VBP;
  localparam int HS_X = HA + HFP;
  localparam int VS_Y = VA + VFP;
  localparam logic SA = 1'b0;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        hsync, vsync;
  logic [5:0]  rrggbb;
  logic        locked, pix_valid, frame_done;
  logic [9:0]  pix_x, pix_y;
  logic [5:0]  pix_rgb;
  logic [15:0] frame_sum;
  logic [18:0] lit_count;
  logic [7:0]  err_count;

  always #5 clk = ~clk;

  vga_rx_monitor #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP),
    .SYNC_ACTIVE(1'b0)
  ) dut (
    .clk(clk), .reset_n(reset_n), .hsync(hsync), .vsync(vsync), .rrggbb(rrggbb),
    .locked(locked), .pix_valid(pix_valid), .pix_x(pix_x), .pix_y(pix_y),
    .pix_rgb(pix_rgb), .frame_done(frame_done), .frame_sum(frame_sum),
    .lit_count(lit_count), .err_count(err_count)
  );

  int vectors = 0, miscompares = 0;
  int cyc = 0, mode = 0;
  int hs_pin_cyc = 0, vs_pin_cyc = 0;
  int lock_rise_cyc = 0, lock_fall_cyc = 0, lock_rises = 0;
  int fd_n = 0, fd_cyc = 0, fd_gap = 0, fd_dbl = 0, fd_sum = 0, fd_lit = 0;
  int hits = 0, hit_x = 0, hit_y = 0, hit_rgb = 0;
  int rises0 = 0;
  logic hs_drv, vs_drv, lk_prev = 1'b0, fd_prev = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [5:0] pat(input int x, input int y);
    case (mode)
      0:       return 6'd0;
      1:       return 6'd1;
      2:       return (x == 5 && y == 3) ? 6'h3F : 6'd0;
      default: return 6'(x + 8 * y);
    endcase
  endfunction

  // One pixel clock: observe outputs at the falling edge, then drive the next input sample
  task automatic step(input logic hs, input logic vs, input logic [5:0] rgb);
    @(negedge clk);
    cyc++;
    if (pix_valid && pix_rgb != 6'd0) begin
      hits++; hit_x = int'(pix_x); hit_y = int'(pix_y); hit_rgb = int'(pix_rgb);
    end
    if (locked && !lk_prev) begin lock_rise_cyc = cyc; lock_rises++; end
    if (!locked && lk_prev) lock_fall_cyc = cyc;
    lk_prev = locked;
    if (frame_done) begin
      if (fd_prev) fd_dbl++;
      fd_n++; fd_gap = cyc - fd_cyc; fd_cyc = cyc;
      fd_sum = int'(frame_sum); fd_lit = int'(lit_count);
    end
    fd_prev = frame_done;
    if (hs == SA && hs_drv != SA) hs_pin_cyc = cyc;
    if (vs == SA && vs_drv != SA) vs_pin_cyc = cyc;
    hsync = hs; vsync = vs; rrggbb = rgb;
    hs_drv = hs; vs_drv = vs;
  endtask

  task automatic gen_line(input int y, input int len);
    logic hs, vs;
    logic [5:0] rgb;
    for (int x = 0; x < len; x++) begin
      hs  = (x >= HS_X && x < HS_X + HSW) ? SA : !SA;
      vs  = (y >= VS_Y && y < VS_Y + VSW) ? SA : !SA;
      rgb = (x < HA && y < VA) ? pat(x, y) : 6'd0;
      step(hs, vs, rgb);
    end
  endtask

  task automatic gen_lines(input int y0, input int n);
    int y = y0;
    for (int i = 0; i < n; i++) begin
      gen_line(y, HT);
      y = (y + 1) % VT;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(!SA, !SA, 6'd0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_locked"},    32'(locked),     32'd0);
    check({tag, "_pix_valid"}, 32'(pix_valid),  32'd0);
    check({tag, "_pix_x"},     32'(pix_x),      32'd0);
    check({tag, "_pix_y"},     32'(pix_y),      32'd0);
    check({tag, "_pix_rgb"},   32'(pix_rgb),    32'd0);
    check({tag, "_frame_done"},32'(frame_done), 32'd0);
    check({tag, "_frame_sum"}, 32'(frame_sum),  32'd0);
    check({tag, "_lit_count"}, 32'(lit_count),  32'd0);
    check({tag, "_err_count"}, 32'(err_count),  32'd0);
  endtask

  initial begin
    reset_n = 1'b0;
    hsync = !SA; vsync = !SA; rrggbb = 6'd0;
    hs_drv = !SA; vs_drv = !SA;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    reset_n = 1'b1;

    // Clean raster: lock on the second vsync edge
    mode = 0;
    gen_lines(0, VT);
    gen_lines(0, VS_Y);
    check("acquire_not_locked", 32'(locked), 32'd0);
    gen_lines(VS_Y, VT - VS_Y);
    check("first_lock", 32'(locked), 32'd1);
    check("first_lock_latency", 32'(lock_rise_cyc - vs_pin_cyc), 32'd2);
    check("no_fd_before_lock", 32'(fd_n), 32'd0);
    gen_lines(0, VT);
    check("first_fd_count", 32'(fd_n), 32'd1);
    check("first_fd_after_lock", 32'(fd_cyc - lock_rise_cyc), 32'(HT * VT));
    gen_lines(0, VT);
    check("fd_count", 32'(fd_n), 32'd2);
    check("fd_period", 32'(fd_gap), 32'(HT * VT));
    check("fd_single_cycle", 32'(fd_dbl), 32'd0);
    check("clean_sum", 32'(fd_sum), 32'd0);
    check("clean_lit", 32'(fd_lit), 32'd0);
    check("clean_err", 32'(err_count), 32'd0);

    // Single lit pixel at (5,3)
    mode = 2; hits = 0;
    gen_lines(0, VT);
    check("hot_hits", 32'(hits), 32'd1);
    check("hot_x", 32'(hit_x), 32'd5);
    check("hot_y", 32'(hit_y), 32'd3);
    check("hot_rgb", 32'(hit_rgb), 32'h3F);
    check("hot_sum", 32'(fd_sum), 32'd63);
    check("hot_lit", 32'(fd_lit), 32'd1);

    // Full-frame constant and gradient patterns
    mode = 1;
    gen_lines(0, VT);
    check("const_sum", 32'(fd_sum), 32'd24);
    check("const_lit", 32'(fd_lit), 32'd24);
    mode = 3;
    gen_lines(0, VT);
    check("grad_sum", 32'(fd_sum), 32'd348);
    check("grad_lit", 32'(fd_lit), 32'd23);
    mode = 0;
    gen_lines(0, 3);
    check("held_sum", 32'(frame_sum), 32'd348);
    check("held_lit", 32'(lit_count), 32'd23);

    // Stretched line 3 -> mismatch at the hsync edge of line 4
    gen_line(3, HT + 1);
    gen_line(4, HT);
    check("linelen_unlock", 32'(locked), 32'd0);
    check("linelen_latency", 32'(lock_fall_cyc - hs_pin_cyc), 32'd2);
    check("linelen_err", 32'(err_count), 32'd1);
    gen_lines(VS_Y, VT - VS_Y);
    gen_lines(0, VS_Y);
    check("relock_wait", 32'(locked), 32'd0);
    gen_lines(VS_Y, VT - VS_Y);
    check("relock", 32'(locked), 32'd1);
    check("relock_latency", 32'(lock_rise_cyc - vs_pin_cyc), 32'd2);
    check("relock_err", 32'(err_count), 32'd1);

    // Sync loss -> timeout 2*H_TOTAL after the last hsync edge
    gen_lines(0, VT);
    idle(30);
    check("loss_unlock", 32'(locked), 32'd0);
    check("loss_latency", 32'(lock_fall_cyc - hs_pin_cyc), 32'(2 * HT + 2));
    check("loss_err", 32'(err_count), 32'd2);
    rises0 = lock_rises;
    for (int i = 0; i < 260; i++) begin
      gen_lines(4, 4);
      gen_lines(0, VT);
      idle(30);
    end
    check("loss_relocks", 32'(lock_rises - rises0), 32'd260);
    check("err_saturate", 32'(err_count), 32'd255);
    check("loss_final_unlock", 32'(locked), 32'd0);

    // Reset asserted mid-line while locked and showing a visible pixel
    gen_lines(4, 4);
    gen_lines(0, VT);
    check("prereset_lock", 32'(locked), 32'd1);
    mode = 3;
    gen_lines(0, 2);
    gen_line(2, 6);
    check("prereset_valid", 32'(pix_valid), 32'd1);
    check("prereset_x", 32'(pix_x), 32'd3);
    check("prereset_y", 32'(pix_y), 32'd2);
    check("prereset_rgb", 32'(pix_rgb), 32'd19);
    reset_n = 1'b0;
    #1;
    check_all_zero("midreset");
    idle(2);
    reset_n = 1'b1;
    mode = 0;
    gen_lines(3, VT - 3);
    check("postreset_acq1", 32'(locked), 32'd0);
    gen_lines(0, VS_Y);
    check("postreset_acq2", 32'(locked), 32'd0);
    gen_lines(VS_Y, VT - VS_Y);
    check("postreset_lock", 32'(locked), 32'd1);
    check("postreset_latency", 32'(lock_rise_cyc - vs_pin_cyc), 32'd2);
    check("postreset_err", 32'(err_count), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
